// File: rtl/cpu_pkg.sv
// Shared ALU definitions: opcode set, default datapath width and divider FSM states.
package cpu_pkg;
  localparam int DATA_W = 32;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} div_state_t;
endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division step on the {acc,q} pair against divisor magnitude m.
module nr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);
  logic [WIDTH:0] shifted;

  always_comb begin
    // acc stays within [-M, M), so the shifted value still fits WIDTH+1 signed bits
    shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
    acc_nxt = acc[WIDTH] ? shifted + {1'b0, m} : shifted - {1'b0, m};
    q_nxt   = {q[WIDTH-2:0], ~acc_nxt[WIDTH]};
  end
endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider for ALU DIV: quotient on Clow, remainder on Chigh, WIDTH+2 cycles.
module seq_divider
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Chigh,
  output logic [WIDTH-1:0] Clow
);
  localparam int CW = $clog2(WIDTH);

  div_state_t       state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q, m;
  logic [CW-1:0]    count;
  logic             neg_a, neg_q;

  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] q_step, rem, quo_s, rem_s, a_orig;

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .q       (q),
    .m       (m),
    .acc_nxt (acc_step),
    .q_nxt   (q_step)
  );

  always_comb begin
    // true remainder lies in [0, M), so restoring modulo 2^WIDTH is exact
    rem    = acc[WIDTH] ? acc[WIDTH-1:0] + m : acc[WIDTH-1:0];
    quo_s  = neg_q ? -q : q;
    rem_s  = neg_a ? -rem : rem;
    // q still holds |A| when the divisor was zero; re-signing recovers A exactly
    a_orig = neg_a ? -q : q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      neg_a       <= 1'b0;
      neg_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Chigh       <= '0;
      Clow        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          neg_a       <= A[WIDTH-1];
          neg_q       <= A[WIDTH-1] ^ B[WIDTH-1];
          q           <= A[WIDTH-1] ? -A : A;
          m           <= B[WIDTH-1] ? -B : B;
          acc         <= '0;
          count       <= '0;
          div_by_zero <= 1'b0;
          busy        <= 1'b1;
          state       <= (B == '0) ? FIX : ITER;
        end
        ITER: begin
          acc   <= acc_step;
          q     <= q_step;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (m == '0) begin
            Clow        <= '1;
            Chigh       <= a_orig;
            div_by_zero <= 1'b1;
          end else begin
            Clow  <= quo_s;
            Chigh <= rem_s;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative signed 32-bit divider serving the DIV opcode (5'b10000) of the datapath ALU. It takes the two ALU operands and produces the quotient and remainder in the ALU's HI/LO result convention: remainder on `Chigh`, quotient on `Clow`. Both results are written into the Z register pair. The control unit drives a start/done handshake and stalls the T-step sequence while `busy` is high. This replaces the single-cycle division path with a 34-cycle non-restoring implementation.

## Interface
- `WIDTH`, 32, operand/result width; must be even and ≥ 4.
- `clock`  in  1  system clock, rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `A`  in  WIDTH  signed dividend.
- `B`  in  WIDTH  signed divisor.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse; results valid in that cycle and held afterwards.
- `div_by_zero`  out  1  set with `done` when B == 0; cleared on the next accepted `start`.
- `Chigh`  out  WIDTH  remainder.
- `Clow`  out  WIDTH  quotient.

## Operation
- States: IDLE, ITER, FIX.
- **IDLE** with `start`=1:
  - Latch the sign of A and the sign of A^B.
  - Load |A| into the Q register, load 0 into the (WIDTH+1)-bit accumulator, and load |B| into M.
  - Set count=0 and clear `div_by_zero`.
  - Next state is ITER, or FIX if B==0.
- **ITER**, one non-restoring step per cycle:
  - Shift {acc,Q} left by one.
  - If acc was non-negative before the shift, acc−=M; otherwise acc+=M.
  - Set Q[0] = ~acc[WIDTH].
  - count++. After step WIDTH (count==WIDTH−1 on entry), go to FIX.
- **FIX**:
  - If acc is negative, acc+=M (remainder restore).
  - Quotient = Q, negated if the A^B sign is set. Remainder = acc[WIDTH-1:0], negated if A was negative. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Register the results to `Clow`/`Chigh`, pulse `done`, and return to IDLE.
- **Divide by zero:** FIX skips the arithmetic. It drives `Clow`=all ones, `Chigh`=A (original signed value), and `div_by_zero`=1.
- **Overflow** (−2^(WIDTH−1) / −1): the result wraps naturally, giving `Clow`=0x80000000 and `Chigh`=0. No flag is raised.
- |A| of the most-negative value is handled as an unsigned magnitude. Q is unsigned WIDTH bits, so there is no loss.
- `start` while busy, or during FIX, is ignored. No queueing.
- **`clear`:** any state goes to IDLE. `busy`, `done`, `div_by_zero`, `Chigh` and `Clow` reset to 0 and the internal registers are zeroed. A `clear` mid-operation discards the operation.
- If `clear` and `start` are both high in the same cycle, `clear` wins.

## Timing
- Let edge k be the edge that samples `start`. `busy`=1 after edges k..k+WIDTH.
- Edges k+1..k+WIDTH perform the iterations. Edge k+WIDTH+1 performs FIX.
- `done`=1 for exactly the cycle after edge k+WIDTH+1: 33 edges from start, so with WIDTH=32, `done` is seen in the 34th cycle counting the start cycle.
- `busy` drops in the same cycle that `done` rises.
- Divide-by-zero: `done` follows edge k+1, a 2-cycle latency.
- Back-to-back: `start` may be asserted in the `done` cycle, because the FSM is already in IDLE, and it is accepted.
- `Chigh`/`Clow` change only at FIX or on `clear`. They are stable between operations.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants (DIV = 5'b10000, plus the rest of the ALU opcode set);
  - the `div_state_t` enum {IDLE, ITER, FIX};
  - the default data width, 32.
- One combinational sub-module, `nr_div_step`: inputs acc, Q and M; outputs the next acc and Q. It is reused per iteration.
- The counter is $clog2(WIDTH) bits wide.

## Test plan
- A=100, B=7, `start` for 1 cycle → `done` in cycle 34; `Clow`=14, `Chigh`=2, `div_by_zero`=0.
- A=−100, B=7 → `Clow`=0xFFFFFFF2 (−14), `Chigh`=0xFFFFFFFE (−2). Then A=100, B=−7 → `Clow`=−14, `Chigh`=2.
- A=0x80000000, B=0xFFFFFFFF → `Clow`=0x80000000, `Chigh`=0. Then A=0x7FFFFFFF, B=1 → `Clow`=0x7FFFFFFF, `Chigh`=0.
- A=5, B=0 → `done` 2 cycles after start, `div_by_zero`=1, `Clow`=0xFFFFFFFF, `Chigh`=5. The next start with 6/3 clears the flag and gives 2 r 0.
- Start 1000/3, pulse `clear` on iteration 10 → `busy`=0 and outputs 0 on the next cycle, and no `done` is produced. Then start 9/3 → 3 r 0 after 34 cycles.
- Start 50/5, re-assert `start` with 7/2 while busy → ignored, result 10 r 0. Asserting `start` in the `done` cycle with 7/2 → result 3 r 1.
